// File: rtl/spi_txn_pkg.sv
// spi_txn_pkg: shared state type, stream addresses and command-byte layout
// for the SPI transaction sequencer.
package spi_txn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4
  } txn_state_t;

  localparam logic [6:0] ADDR_TX_PKT = 7'h03;
  localparam logic [6:0] ADDR_RX_PKT = 7'h05;
  localparam logic [6:0] ADDR_FIFO   = 7'h08;

  localparam int CMD_RW_BIT = 7;

  function automatic logic is_stream_addr(input logic [6:0] a);
    return (a == ADDR_TX_PKT) || (a == ADDR_RX_PKT) || (a == ADDR_FIFO);
  endfunction

endpackage

// File: rtl/spi_txn_addr_gen.sv
// spi_txn_addr_gen: register address for the current transaction.
// SPI_BURST_AUTOINC_EN: step after each access; else hold one address.
module spi_txn_addr_gen
  import spi_txn_pkg::*;
#(
  parameter int                ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 7'h09
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] next;

`ifdef SPI_BURST_AUTOINC_EN
  // Step to the next register, wrapping past the top; streams hold.
  always_comb begin
    next = addr;
    if (advance && !is_stream_addr(7'(addr))) begin
      next = (addr >= MAX_ADDR) ? '0 : addr + 1'b1;
    end
  end
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign next = addr;
`endif

  // Command byte loads the address; otherwise step or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_addr;
    end else begin
      addr <= next;
    end
  end

endmodule

// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: SPI command/burst sequencer feeding the register mux.
// Option SPI_BURST_AUTOINC_EN (in spi_txn_addr_gen): burst address step.
module spi_txn_ctrl
  import spi_txn_pkg::*;
#(
  parameter int                ADDR_W    = 7,
  parameter logic [ADDR_W-1:0] MAX_ADDR  = 7'h09,
  parameter int                BURST_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              byte_dv,
  input  logic [7:0]        byte_in,
  input  logic              tx_load_req,
  input  logic              tx_en,
  input  logic [7:0]        tx_d,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              addr_dv,
  output logic              rw_out,
  output logic              rxdv,
  output logic [7:0]        rx_d,
  output logic [7:0]        tx_byte,
  output logic              tx_byte_vld,
  output logic              rd_ack,
  output logic              addr_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  txn_state_t state, state_nx;

  logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        rx_d_nx, tx_byte_nx;
  logic addr_dv_nx, rw_nx, rxdv_nx, vld_nx;
  logic ack_nx, err_nx, samp, samp_nx, load;

  assign cnt_inc  = cnt + 1'b1;
  assign cmd_addr = byte_in[ADDR_W-1:0];
  assign busy     = (state != IDLE);

  spi_txn_addr_gen #(
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAX_ADDR)
  ) u_addr (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_addr (cmd_addr),
    .advance   (rxdv | rd_ack),
    .addr      (reg_addr)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered outputs, burst count and pending read-sample flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      addr_dv     <= 1'b0;
      rw_out      <= 1'b0;
      rxdv        <= 1'b0;
      rx_d        <= 8'h00;
      tx_byte     <= 8'h00;
      tx_byte_vld <= 1'b0;
      rd_ack      <= 1'b0;
      addr_err    <= 1'b0;
      samp        <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      addr_dv     <= addr_dv_nx;
      rw_out      <= rw_nx;
      rxdv        <= rxdv_nx;
      rx_d        <= rx_d_nx;
      tx_byte     <= tx_byte_nx;
      tx_byte_vld <= vld_nx;
      rd_ack      <= ack_nx;
      addr_err    <= err_nx;
      samp        <= samp_nx;
    end
  end

  // Next state and output decode; cs_n high aborts any transaction.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    addr_dv_nx = addr_dv;
    rw_nx      = rw_out;
    rxdv_nx    = 1'b0;
    rx_d_nx    = rx_d;
    tx_byte_nx = tx_byte;
    vld_nx     = tx_byte_vld;
    ack_nx     = 1'b0;
    err_nx     = addr_err;
    samp_nx    = samp;
    load       = 1'b0;
    if (state != IDLE && cs_n) begin
      state_nx   = IDLE;
      cnt_nx     = '0;
      addr_dv_nx = 1'b0;
      vld_nx     = 1'b0;
      samp_nx    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!cs_n) begin
            state_nx = CMD;
            err_nx   = 1'b0;
          end
        end
        CMD: begin
          if (byte_dv) begin
            load  = 1'b1;
            rw_nx = byte_in[CMD_RW_BIT];
            if (cmd_addr > MAX_ADDR) begin
              state_nx = DRAIN;
              err_nx   = 1'b1;
            end else begin
              addr_dv_nx = 1'b1;
              samp_nx    = byte_in[CMD_RW_BIT];
              state_nx   = byte_in[CMD_RW_BIT] ? READ : WRITE;
            end
          end
        end
        WRITE: begin
          if (byte_dv) begin
            rx_d_nx = byte_in;
            rxdv_nx = 1'b1;
            cnt_nx  = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_nx   = DRAIN;
              addr_dv_nx = 1'b0;
            end
          end
        end
        READ: begin
          if (samp) begin
            tx_byte_nx = tx_en ? tx_d : 8'h00;
            vld_nx     = 1'b1;
            samp_nx    = 1'b0;
          end else if (rd_ack) begin
            samp_nx = 1'b1;
          end
          if (tx_load_req && tx_byte_vld) begin
            ack_nx = 1'b1;
            vld_nx = 1'b0;
            cnt_nx = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_nx   = DRAIN;
              addr_dv_nx = 1'b0;
            end
          end
        end
        DRAIN: begin
          addr_dv_nx = 1'b0;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb_spi_txn_ctrl: directed scenarios plus randomized transactions,
// checked every cycle against a transaction-level reference model.
module tb_spi_txn_ctrl;

  localparam int BURST_MAX = 255;
  localparam int P_IDLE = 0, P_CMD = 1, P_WRITE = 2, P_READ = 3, P_DRAIN = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs_n = 1'b1;
  logic byte_dv = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic tx_load_req = 1'b0;
  logic tx_en;
  logic [7:0] tx_d;
  logic [6:0] reg_addr;
  logic addr_dv, rw_out, rxdv, tx_byte_vld, rd_ack, addr_err, busy;
  logic [7:0] rx_d, tx_byte;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  spi_txn_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cs_n        (cs_n),
    .byte_dv     (byte_dv),
    .byte_in     (byte_in),
    .tx_load_req (tx_load_req),
    .tx_en       (tx_en),
    .tx_d        (tx_d),
    .reg_addr    (reg_addr),
    .addr_dv     (addr_dv),
    .rw_out      (rw_out),
    .rxdv        (rxdv),
    .rx_d        (rx_d),
    .tx_byte     (tx_byte),
    .tx_byte_vld (tx_byte_vld),
    .rd_ack      (rd_ack),
    .addr_err    (addr_err),
    .busy        (busy)
  );

  // ---------------- register mux stand-in ----------------
  logic [7:0] mem [0:127];
  logic       en_mask [0:127];
  logic [3:0] popc [0:15];
  bit         clr_pop = 1'b1;

  function automatic logic strm(input logic [6:0] a);
    return a == 7'h03 || a == 7'h05 || a == 7'h08;
  endfunction

  assign tx_d = strm(reg_addr)
              ? {popc[reg_addr[3:0]] + 4'd1,
                 (reg_addr == 7'h08) ? 4'h0 : reg_addr[3:0]}
              : mem[reg_addr];
  assign tx_en = strm(reg_addr) ? 1'b1 : en_mask[reg_addr];

  always @(posedge clk) begin
    if (clr_pop) begin
      for (int i = 0; i < 16; i++) popc[i] <= 4'd0;
    end else if (rd_ack && strm(reg_addr)) begin
      popc[reg_addr[3:0]] <= popc[reg_addr[3:0]] + 4'd1;
    end
  end

  // ---------------- reference model ----------------
  int ph = P_IDLE;
  logic [6:0] m_addr = 0;
  logic m_rw = 0, m_dv = 0, m_rxdv = 0, m_vld = 0, m_ack = 0, m_err = 0;
  logic [7:0] m_rxd = 0, m_txb = 0;
  int m_cnt = 0;
  longint cyc = 0;
  longint samp_at = -1;
  logic pulse, old_vld;

  function automatic logic [6:0] adv(input logic [6:0] a);
`ifdef SPI_BURST_AUTOINC_EN
    if (strm(a)) return a;
    return (a >= 7'h09) ? 7'h00 : a + 7'd1;
`else
    return a;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = P_IDLE; m_addr = 0; m_rw = 0; m_dv = 0; m_rxdv = 0;
      m_rxd = 0; m_txb = 0; m_vld = 0; m_ack = 0; m_err = 0;
      m_cnt = 0; samp_at = -1;
    end else begin
      cyc++;
      pulse = m_rxdv || m_ack;
      old_vld = m_vld;
      m_rxdv = 0;
      m_ack = 0;
      if (pulse) m_addr = adv(m_addr);
      if (ph != P_IDLE && cs_n) begin
        ph = P_IDLE; m_dv = 0; m_vld = 0; m_cnt = 0; samp_at = -1;
      end else begin
        case (ph)
          P_IDLE: if (!cs_n) begin ph = P_CMD; m_err = 0; end
          P_CMD: if (byte_dv) begin
            m_addr = byte_in[6:0];
            m_rw = byte_in[7];
            if (byte_in[6:0] > 7'h09) begin
              ph = P_DRAIN; m_err = 1;
            end else begin
              m_dv = 1;
              ph = m_rw ? P_READ : P_WRITE;
              if (m_rw) samp_at = cyc + 1;
            end
          end
          P_WRITE: if (byte_dv) begin
            m_rxd = byte_in; m_rxdv = 1; m_cnt++;
            if (m_cnt == BURST_MAX) begin ph = P_DRAIN; m_dv = 0; end
          end
          P_READ: begin
            if (cyc == samp_at) begin
              m_txb = tx_en ? tx_d : 8'h00; m_vld = 1;
            end
            if (tx_load_req && old_vld) begin
              m_ack = 1; m_vld = 0; m_cnt++; samp_at = cyc + 2;
              if (m_cnt == BURST_MAX) begin ph = P_DRAIN; m_dv = 0; end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [29:0] got_v, exp_v;
  always @(negedge clk) begin
    if (run) begin
      got_v = {reg_addr, addr_dv, rw_out, rxdv, rx_d, tx_byte,
               tx_byte_vld, rd_ack, addr_err, busy};
      exp_v = {m_addr, m_dv, m_rw, m_rxdv, m_rxd, m_txb,
               m_vld, m_ack, m_err, ph != P_IDLE};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t got %h expected %h", $time, got_v, exp_v);
      end
    end
  end

  // ---------------- event logs ----------------
  logic [14:0] rx_log[$];
  int ack_cnt = 0;
  bit dv_seen = 1'b0;
  always @(negedge clk) begin
    if (rxdv) rx_log.push_back({reg_addr, rx_d});
    if (rd_ack) ack_cnt++;
    if (addr_dv) dv_seen = 1'b1;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    byte_dv = 1'b1;
    byte_in = b;
    tick();
    byte_dv = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic load_pulse();
    tx_load_req = 1'b1;
    tick();
    tx_load_req = 1'b0;
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    repeat (2) tick();
  endtask

  task automatic cs_hi();
    cs_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic clr_logs();
    rx_log.delete();
    ack_cnt = 0;
    dv_seen = 1'b0;
  endtask

  task automatic wait_vld();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_byte_vld) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_vld tx_byte_vld=0 required 1 within 20 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cmd;
    int n;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'($urandom);
      en_mask[i] = 1'($urandom);
    end
    mem[6] = 8'h5A;
    en_mask[6] = 1'b1;
    repeat (2) tick();
    run = 1'b1;
    tick();
    chk("reset_outs", 32'({reg_addr, addr_dv, rw_out, rxdv, rx_d, tx_byte,
        tx_byte_vld, rd_ack, addr_err, busy}), 32'h0);
    reset = 1'b0;
    clr_pop = 1'b0;
    repeat (2) tick();

    // single write
    clr_logs();
    cs_lo();
    send(8'h06, 2);
    chk("wr_addr", 32'(reg_addr), 32'h06);
    chk("wr_addr_dv", 32'(addr_dv), 32'h1);
    chk("wr_rw", 32'(rw_out), 32'h0);
    send(8'hA5, 3);
    chk("wr_count", 32'(rx_log.size()), 32'd1);
    chk("wr_strobe", 32'(rx_log[0]), 32'({7'h06, 8'hA5}));
    cs_hi();

    // burst write
    clr_logs();
    cs_lo();
    send(8'h00, 2);
    send(8'h11, 2);
    send(8'h22, 3);
    chk("burst_count", 32'(rx_log.size()), 32'd2);
    chk("burst_0", 32'(rx_log[0]), 32'({7'h00, 8'h11}));
`ifdef SPI_BURST_AUTOINC_EN
    chk("burst_1", 32'(rx_log[1]), 32'({7'h01, 8'h22}));
`else
    chk("burst_1", 32'(rx_log[1]), 32'({7'h00, 8'h22}));
`endif
    cs_hi();

    // FIFO read burst
    clr_pop = 1'b1;
    tick();
    clr_pop = 1'b0;
    clr_logs();
    cs_lo();
    send(8'h88, 1);
    wait_vld();
    chk("fifo_b0", 32'(tx_byte), 32'h10);
    load_pulse();
    tick();
    wait_vld();
    chk("fifo_b1", 32'(tx_byte), 32'h20);
    load_pulse();
    repeat (3) tick();
    chk("fifo_acks", 32'(ack_cnt), 32'd2);
    chk("fifo_addr", 32'(reg_addr), 32'h08);
    cs_hi();

    // bad address
    clr_logs();
    cs_lo();
    send(8'h0F, 3);
    chk("bad_err", 32'(addr_err), 32'h1);
    chk("bad_dv_seen", 32'(dv_seen), 32'h0);
    chk("bad_no_rxdv", 32'(rx_log.size()), 32'd0);
    cs_hi();
    chk("bad_sticky", 32'(addr_err), 32'h1);
    cs_lo();
    chk("bad_clear", 32'(addr_err), 32'h0);
    cs_hi();

    // abort with coincident byte
    clr_logs();
    cs_n = 1'b0;
    repeat (2) tick();
    byte_dv = 1'b1;
    byte_in = 8'h01;
    tick();
    cs_n = 1'b1;
    byte_in = 8'h5C;
    tick();
    byte_dv = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_dv", 32'(addr_dv), 32'h0);
    repeat (3) tick();
    chk("abort_no_rxdv", 32'(rx_log.size()), 32'd0);

    // reset during read
    cs_lo();
    send(8'h86, 1);
    wait_vld();
    reset = 1'b1;
    #1;
    chk("rst_outs", 32'({reg_addr, addr_dv, rw_out, rxdv, rx_d, tx_byte,
        tx_byte_vld, rd_ack, addr_err, busy}), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    send(8'h86, 1);
    wait_vld();
    chk("rst_rd_byte", 32'(tx_byte), 32'h5A);
    chk("rst_rd_addr", 32'(reg_addr), 32'h06);
    chk("rst_rd_rw", 32'(rw_out), 32'h1);
    cs_hi();

    // burst limit
    clr_logs();
    cs_lo();
    send(8'h02, 1);
    for (int i = 0; i < 256; i++) send(8'(i), 1);
    tick();
    chk("max_count", 32'(rx_log.size()), 32'd255);
    chk("max_last", 32'(rx_log[$][7:0]), 32'hFE);
    chk("max_dv", 32'(addr_dv), 32'h0);
    chk("max_busy", 32'(busy), 32'h1);
    cs_hi();

    // randomized transactions
    for (int t = 0; t < 80; t++) begin
      cmd[7] = 1'($urandom_range(0, 1));
      cmd[6:0] = 7'($urandom_range(0, 12));
      n = $urandom_range(0, 6);
      cs_lo();
      send(cmd, $urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) begin
        cs_n = 1'b1;
        byte_dv = 1'b1;
        byte_in = 8'($urandom);
        tick();
        byte_dv = 1'b0;
        repeat (2) tick();
      end else begin
        for (int k = 0; k < n; k++) begin
          if (cmd[7]) begin
            repeat ($urandom_range(0, 4)) tick();
            load_pulse();
          end else begin
            send(8'($urandom), $urandom_range(1, 4));
          end
        end
        if ($urandom_range(0, 14) == 0) begin
          reset = 1'b1;
          repeat (2) tick();
          reset = 1'b0;
          tick();
        end
        repeat (3) tick();
        cs_hi();
      end
    end

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_txn_ctrl.md
Name: spi_txn_ctrl

Overview:
Transaction sequencer between the SPI slave byte engine and the register mux/demux. It parses the command byte ({rw, addr[6:0]}), drives addr_dv/rw_out/reg_addr/rxdv/rx_d to the register mux, and handles multi-byte bursts. For reads it captures mux tx_d/tx_en into a one-byte holding register for the shifter, and issues rd_ack so streaming registers (packet, FIFO) advance per byte.

Parameters:
ADDR_W, 7, register address width
MAX_ADDR, 7'h09, highest decoded register address
BURST_MAX, 255, max data bytes per transaction; further bytes are dropped

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cs_n  input  1  chip select, already synchronised to clk, active-low
byte_dv  input  1  one-cycle pulse: byte_in holds a complete received byte
byte_in  input  8  received SPI byte
tx_load_req  input  1  one-cycle pulse: shifter consumed tx_byte
tx_en  input  1  register mux read-data valid
tx_d  input  8  register mux read data
reg_addr  output  7  current register address
addr_dv  output  1  address valid for the whole data phase
rw_out  output  1  1 = read to host, 0 = write from host
rxdv  output  1  one-cycle write strobe
rx_d  output  8  write data, held until next write
tx_byte  output  8  byte presented to the shifter
tx_byte_vld  output  1  tx_byte valid
rd_ack  output  1  one-cycle pulse: read byte consumed
addr_err  output  1  sticky; cleared at next cs_n fall
busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; byte_cnt 0.
- States: IDLE, CMD, WRITE, READ, DRAIN.
- IDLE -> CMD when cs_n==0; clears addr_err.
- CMD, on byte_dv:
  - latch rw_out=byte_in[7], reg_addr=byte_in[6:0].
  - addr_dv=1 next cycle.
  - addr > MAX_ADDR -> DRAIN, addr_err=1, addr_dv stays 0.
  - else rw? READ : WRITE.
- WRITE, on byte_dv:
  - rx_d=byte_in; rxdv high exactly one cycle, 1 cycle after byte_dv.
  - byte_cnt++; reg_addr updates the cycle after rxdv.
  - byte_cnt==BURST_MAX -> DRAIN.
- READ:
  - 1 cycle after addr_dv rises: tx_byte = tx_en ? tx_d : 8'h00, tx_byte_vld=1.
  - On tx_load_req: rd_ack pulse same cycle as tx_load_req is registered (1-cycle latency), tx_byte_vld=0, address advance.
  - Re-sample tx_d 1 cycle after rd_ack, so a popped stream register shows new data.
  - tx_load_req while tx_byte_vld==0: ignored, no rd_ack. The shifter sends its idle byte.
  - byte_cnt counts rd_acks; at BURST_MAX -> DRAIN.
- DRAIN: ignore byte_dv/tx_load_req; addr_dv=0.
- cs_n==1 in any non-IDLE state has priority over all other events:
  - next cycle IDLE; addr_dv, rxdv, tx_byte_vld, rd_ack = 0; byte_cnt=0.
  - A byte_dv coincident with cs_n==1 is dropped.
- Stream addresses (0x03 tx_packet, 0x05 rx_packet, 0x08 fifo) never advance.
- Address wrap: advance past MAX_ADDR wraps to 0x00.
- Reset mid-transaction: immediate return to reset values; no rxdv/rd_ack emitted.

Optional Feature:
SPI_BURST_AUTOINC_EN.
- Defined: non-stream addresses increment by 1 after each write strobe or rd_ack.
- Undefined: reg_addr is fixed for the whole transaction; bursts repeatedly access one register.

Decomposition:
- Package spi_txn_pkg holds:
  - state enum txn_state_t
  - ADDR_FIFO / ADDR_TX_PKT / ADDR_RX_PKT constants
  - is_stream_addr() function
  - CMD_RW_BIT index
- Sub-module spi_txn_addr_gen: address register with load/advance/wrap/stream-hold. Feature macro applies here.

Test Plan:
- Single write, cs low, byte 0x06 then 0xA5 -> addr_dv=1, reg_addr=0x06, rw_out=0; one rxdv pulse with rx_d=0xA5.
- Burst write, 0x00, 0x11, 0x22 with SPI_BURST_AUTOINC_EN -> rxdv at addr 0x00 data 0x11, then addr 0x01 data 0x22. Without the macro -> both strobes at addr 0x00.
- FIFO read burst, 0x88 with tx_d sequence 0x10, 0x20 on each rd_ack, 2 tx_load_req -> tx_byte 0x10 then 0x20; 2 rd_ack pulses; reg_addr stays 0x08.
- Bad address, 0x0F -> addr_err=1, addr_dv never asserted, no rxdv; addr_err clears on next cs_n fall.
- Abort, cs_n rises 1 cycle after command byte 0x01 with coincident byte_dv -> no rxdv, IDLE next cycle, busy=0.
- Reset asserted during READ with tx_byte_vld=1 -> all outputs 0 immediately; after release, a new 0x86 command works normally.
